// File: rtl/mt9_pkg.sv
// Shared types for the MT9-style synthetic sensor source: FSM state and
// test-pattern encodings plus small elaboration-time helpers.
package mt9_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FRAME  = 2'd1,
        VBLANK = 2'd2
    } mt9_state_e;

    typedef enum logic [1:0] {
        PAT_HRAMP  = 2'd0,
        PAT_VRAMP  = 2'd1,
        PAT_CHECK  = 2'd2,
        PAT_MOVING = 2'd3
    } mt9_pattern_e;

    localparam int FRAME_CNT_W = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mt9_pattern_gen_if.sv
// Video bus between the synthetic sensor and the sampler: vsync envelope,
// href line-valid and pixel data.
interface mt9_pattern_gen_if #(
    parameter int PIXEL_WIDTH = 8
);

    // Source-timed stream with no backpressure: pixel is valid exactly on
    // href-high cycles inside a vsync-high envelope; the sink takes every one.
    logic                   vsync;
    logic                   href;
    logic [PIXEL_WIDTH-1:0] pixel;

    modport master (
        output vsync,
        output href,
        output pixel
    );

    modport slave (
        input vsync,
        input href,
        input pixel
    );

endinterface

// File: rtl/mt9_line_timer.sv
// Horizontal pixel counter and line counter for the pattern generator.
// clear_i restarts both at zero; line_wrap_o marks the last cycle of a line.
module mt9_line_timer #(
    parameter int LINE_LEN = 800,
    parameter int HCNT_W   = 10,
    parameter int VLINE_W  = 9
) (
    input  logic               pclk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    output logic [HCNT_W-1:0]  hcnt_o,
    output logic [VLINE_W-1:0] vline_o,
    output logic               line_wrap_o
);

    logic [HCNT_W-1:0]  hcnt_q;
    logic [HCNT_W-1:0]  hcnt_d;
    logic [VLINE_W-1:0] vline_q;
    logic [VLINE_W-1:0] vline_d;

    assign line_wrap_o = (hcnt_q == HCNT_W'(LINE_LEN - 1));
    assign hcnt_o      = hcnt_q;
    assign vline_o     = vline_q;

    // Clear wins over wrap so a state change always starts on a fresh line 0.
    always_comb begin
        hcnt_d  = hcnt_q + 1'b1;
        vline_d = vline_q;
        if (clear_i) begin
            hcnt_d  = '0;
            vline_d = '0;
        end else if (line_wrap_o) begin
            hcnt_d  = '0;
            vline_d = vline_q + 1'b1;
        end
    end

    always_ff @(posedge pclk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hcnt_q  <= '0;
            vline_q <= '0;
        end else begin
            hcnt_q  <= hcnt_d;
            vline_q <= vline_d;
        end
    end

endmodule

// File: rtl/mt9_pattern_gen.sv
// Synthetic MT9-style sensor: frames/lines with vsync/href framing and a
// selectable test pattern, all outputs registered in the pixel-clock domain.
module mt9_pattern_gen
    import mt9_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 160,
    parameter int V_FRONT     = 4,
    parameter int V_ACTIVE    = 480,
    parameter int V_BACK      = 4,
    parameter int V_LOW       = 8
) (
    input  logic                   pclk_i,
    input  logic                   reset_n_i,
    input  logic                   enable_i,
    input  logic [1:0]             pattern_i,
    mt9_pattern_gen_if.master      vid,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o,
    output logic                   busy_o,
    output mt9_state_e             dbg_state_o
);

    localparam int LINE_LEN    = H_ACTIVE + H_BLANK;
    localparam int FRAME_LINES = V_FRONT + V_ACTIVE + V_BACK;
    localparam int VLINE_MAX   = max_int(FRAME_LINES, V_LOW);
    localparam int HCNT_W      = $clog2(LINE_LEN);
    localparam int VLINE_W     = $clog2(VLINE_MAX + 1);

    mt9_state_e             state_q;
    mt9_state_e             state_d;
    mt9_pattern_e           pat_q;
    mt9_pattern_e           pat_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_d;

    logic                   vsync_q;
    logic                   vsync_d;
    logic                   href_q;
    logic                   href_d;
    logic [PIXEL_WIDTH-1:0] pixel_q;
    logic [PIXEL_WIDTH-1:0] pixel_d;
    logic [FRAME_CNT_W-1:0] fcnt_out_q;
    logic [FRAME_CNT_W-1:0] fcnt_out_d;
    logic                   busy_q;
    logic                   busy_d;

    logic                   timer_clear;
    logic [HCNT_W-1:0]      hcnt;
    logic [VLINE_W-1:0]     vline;
    logic                   line_wrap;
    logic                   frame_end;
    logic                   blank_end;
    logic                   in_active;
    logic [PIXEL_WIDTH-1:0] pattern_px;

    mt9_line_timer #(
        .LINE_LEN (LINE_LEN),
        .HCNT_W   (HCNT_W),
        .VLINE_W  (VLINE_W)
    ) u_line_timer (
        .pclk_i      (pclk_i),
        .reset_n_i   (reset_n_i),
        .clear_i     (timer_clear),
        .hcnt_o      (hcnt),
        .vline_o     (vline),
        .line_wrap_o (line_wrap)
    );

    assign frame_end = line_wrap && (vline == VLINE_W'(FRAME_LINES - 1));
    assign blank_end = line_wrap && (vline == VLINE_W'(V_LOW - 1));

    // enable_i is looked at only in IDLE and on the last VBLANK cycle, so a
    // frame once started always runs to completion with its blanking.
    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        frame_cnt_d = frame_cnt_q;
        timer_clear = 1'b0;
        case (state_q)
            IDLE: begin
                timer_clear = 1'b1;
                if (enable_i) begin
                    state_d = FRAME;
                    pat_d   = mt9_pattern_e'(pattern_i);
                end
            end
            FRAME: begin
                if (frame_end) begin
                    state_d     = VBLANK;
                    timer_clear = 1'b1;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
            VBLANK: begin
                if (blank_end) begin
                    timer_clear = 1'b1;
                    if (enable_i) begin
                        state_d = FRAME;
                        pat_d   = mt9_pattern_e'(pattern_i);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                timer_clear = 1'b1;
            end
        endcase
    end

    assign in_active = (state_q == FRAME)
                    && (vline >= VLINE_W'(V_FRONT))
                    && (vline <  VLINE_W'(V_FRONT + V_ACTIVE))
                    && (hcnt  <  HCNT_W'(H_ACTIVE));

    // y is the line index relative to the first active line; all results are
    // truncated to the pixel width.
    always_comb begin
        pattern_px = '0;
        case (pat_q)
            PAT_HRAMP:  pattern_px = PIXEL_WIDTH'(hcnt);
            PAT_VRAMP:  pattern_px = PIXEL_WIDTH'(32'(vline) - 32'(V_FRONT));
            PAT_CHECK:  pattern_px = (((32'(hcnt) ^ (32'(vline) - 32'(V_FRONT))) & 32'd8) != 32'd0)
                                     ? '1 : '0;
            PAT_MOVING: pattern_px = PIXEL_WIDTH'(32'(hcnt) + 32'(frame_cnt_q[7:0]));
            default:    pattern_px = '0;
        endcase
    end

    // Every output is a one-cycle-delayed view of the current state/counters.
    always_comb begin
        vsync_d    = (state_q == FRAME);
        href_d     = in_active;
        pixel_d    = in_active ? pattern_px : '0;
        fcnt_out_d = frame_cnt_q;
        busy_d     = (state_q != IDLE);
    end

    always_ff @(posedge pclk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            pat_q       <= PAT_HRAMP;
            frame_cnt_q <= '0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            pixel_q     <= '0;
            fcnt_out_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            frame_cnt_q <= frame_cnt_d;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            pixel_q     <= pixel_d;
            fcnt_out_q  <= fcnt_out_d;
            busy_q      <= busy_d;
        end
    end

    assign vid.vsync   = vsync_q;
    assign vid.href    = href_q;
    assign vid.pixel   = pixel_q;
    assign frame_cnt_o = fcnt_out_q;
    assign busy_o      = busy_q;
    assign dbg_state_o = state_q;

endmodule
